// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_MIN_DIV = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head word and registered occupancy.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic                     full_c,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             do_push, do_pop;

  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && (!full_c || do_pop);

  // Head lookahead: the new head may be the word being written this cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    head_d   = head_q;
    if (level_d != '0) begin
      head_d = (do_push && (rd_ptr_d == wr_ptr_q)) ? wdata_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= (level_d != '0);
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM, byte FIFO, sticky errors and irq.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic [DIV_W-1:0]       clk_div,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic                   err_clr,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   irq
);

  localparam int unsigned BIT_W = $clog2(UART_DATA_W);

  rx_state_e              state_q, state_d;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIV_W-1:0]       cnt_q, cnt_d, div_q, div_d, eff_div;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   frame_err_q, overrun_q, irq_q;
  logic                   push_c, set_fe_c, set_ov_c, pop_c, full_c, expire;

  assign eff_div = (clk_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : clk_div;
  assign expire  = (cnt_q <= DIV_W'(1));
  assign pop_c   = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, bit timing and byte-complete decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_c   = 1'b0;
    set_fe_c = 1'b0;
    set_ov_c = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          div_d   = eff_div;
          cnt_d   = eff_div >> 1;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (!expire) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (!rx_s_q) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = RX_DATA;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          shift_d = {rx_s_q, shift_q[UART_DATA_W-1:1]};
          cnt_d   = div_q;
          if (bit_q == BIT_W'(UART_DATA_W - 1)) state_d = RX_STOP;
          else                                  bit_d   = bit_q + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (rx_s_q) begin
          state_d = RX_IDLE;
          if (!full_c || pop_c) push_c   = 1'b1;
          else                  set_ov_c = 1'b1;
        end else begin
          set_fe_c = 1'b1;
          state_d  = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      div_q       <= DIV_W'(UART_MIN_DIV);
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= set_fe_c | (frame_err_q & ~err_clr);
      overrun_q   <= set_ov_c | (overrun_q & ~err_clr);
      irq_q       <= rx_valid | frame_err_q | overrun_q;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .wdata_i (shift_q),
    .pop_i   (pop_c),
    .full_c  (full_c),
    .valid_o (rx_valid),
    .head_o  (rx_data),
    .level_o (fifo_level)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign irq       = irq_q;

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-parallel UART receive stage for the user project. It accepts the 8N1 line driven into the chip on the UART RX pad (the stream produced by the bench UART transmitter), validates start and stop bits, and buffers received bytes in a small FIFO. Firmware-side logic drains the FIFO through a valid/ready handshake. Sticky error flags and an interrupt request are exported to the register block.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the bit-period divider.

Ports:
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  raw serial line; asynchronous, idle high.
- `clk_div`  in  DIV_W  clocks per bit; values <4 are treated as 4.
- `rx_data`  out  8  FIFO head byte.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pops the head when `rx_valid && rx_ready`.
- `err_clr`  in  1  one-cycle pulse that clears both sticky errors.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `overrun`  out  1  sticky; a good byte arrived while the FIFO was full and was dropped.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `irq`  out  1  `rx_valid | frame_err | overrun`, registered.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). All decisions use `rx_s`.
- The FSM has five states: IDLE, START, DATA, STOP, BREAK.
- IDLE: a falling `rx_s` (1→0) latches `clk_div` into `div_q`, loads the counter with `div_q>>1`, and enters START.
- START: when the counter expires, sample `rx_s`. If it is 0, reload the counter with `div_q` and enter DATA with bit index 0. If it is 1, treat it as a glitch and return to IDLE with no flags set.
- DATA: on each expiry, shift `rx_s` into bit 7 of the shift register (LSB first) and reload. After bit 7, enter STOP.
- STOP: on expiry, sample `rx_s`.
  - If it is 1 and the FIFO is not full, or the FIFO is full but a pop occurs in the same cycle, push the byte and go to IDLE.
  - If it is 1 and the FIFO is full with no pop, drop the byte, set `overrun`, and go to IDLE.
  - If it is 0, discard the byte, set `frame_err`, and go to BREAK.
- BREAK: wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from restarting reception.
- FIFO behaviour:
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - A pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - `rx_data` is registered and shows the head entry; it holds its last value while empty.
- Sticky flags:
  - If `err_clr` and a new error event occur in the same cycle, the set wins.
  - `err_clr` does not affect FIFO contents.
- A mid-operation `rst_n` assertion immediately sets: FSM to IDLE, FIFO empty, flags 0. The synchronizer flops reset to 1.

## Timing
- Reset values:
  - `rx_data` = 0x00
  - `rx_valid` = 0
  - `frame_err` = 0
  - `overrun` = 0
  - `fifo_level` = 0
  - `irq` = 0
- Synchronizer latency is 2 clocks.
- Start validation occurs `div_q>>1` clocks after the falling edge is seen on `rx_s`. Each data bit and the stop bit are sampled `div_q` clocks apart, i.e. at mid-bit.
- `rx_valid` and `rx_data` update 1 clock after the stop-bit sample cycle.
- `frame_err` and `overrun` assert 1 clock after the stop-bit sample.
- `irq` follows its sources with 1 extra clock.
- Changing `clk_div` mid-frame has no effect until the next start bit.

## Structure
- Package `uart_pkg`: FSM state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`, `RX_BREAK`), `UART_DATA_W = 8`, `UART_MIN_DIV = 4`.
- Sub-module `uart_rx_fifo`: synchronous FIFO parameterized by DEPTH and width. It provides push/pop/full/empty/level and a registered head output.
- The top level holds the synchronizer, FSM, counter, shift register and flags.

## Test plan
- `clk_div=16`, send 0x0F at 16 clocks/bit, `rx_ready=1` → `rx_data=0x0F` with `rx_valid` high for one cycle, 1 clock after the stop sample; no flags.
- `clk_div=16`, send 0x0F then 0x3D back-to-back with `rx_ready=0` → `fifo_level=2`; pops return 0x0F then 0x3D.
- `rx` low for 4 clocks then high, `clk_div=16` → no push, `fifo_level=0`, no flags, FSM back in IDLE.
- Send 0xA5 with the stop bit forced 0 and the line held low 40 clocks → `frame_err=1`, no push, no new byte until the line returns high; then `err_clr` → `frame_err=0`.
- `DEPTH=4`, `rx_ready=0`, send 0x01..0x05 → `fifo_level=4`, `overrun=1`; pops yield 0x01..0x04.
- Assert `rst_n=0` mid-DATA of 0x3D, release, send 0x0F → only 0x0F is received; all flags 0.
